// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: queue entry, FSM states,
// outstanding-request record and the default reset PC.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        epoch;
    } pending_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instructions toward decode, with a flush that
// empties it in one cycle. Flush wins over push, push and pop may coincide.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   entries [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  occ;
    logic           do_pop;

    assign do_pop = pop && (occ != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage is data only; occupancy and pointers define what is meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) entries[wr_ptr] <= push_entry;
    end

    assign head  = entries[rd_ptr];
    assign valid = (occ != '0);
    assign count = occ;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues one imem request at a time, steers on
// predictor hits and queues fetched words (with their prediction) for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] bpPc,
    input  logic        bpHit,
    input  logic [31:0] bpTarget,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemReqReady,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        decValid,
    input  logic        decReady,
    output logic [31:0] decInstr,
    output logic [31:0] decPc,
    output logic        decPredTaken,
    output logic [31:0] decPredTarget
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   pc;
    logic          epoch;
    pending_t      pend;

    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          req_valid;
    logic          accept;
    logic          rsp_fire;
    logic          push;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic          head_valid;

    // An outstanding request already owns a queue slot, so it counts as occupied.
    assign occupancy = count + CW'(state == WAIT);

    always_comb begin
        state_nxt = state;
        req_valid = !rst && !redirectValid
                    && ((state == IDLE) || imemRspValid)
                    && (occupancy < CW'(FQ_DEPTH));
        accept    = req_valid && imemReqReady;
        rsp_fire  = (state == WAIT) && imemRspValid;
        push      = rsp_fire && (pend.epoch == epoch) && !redirectValid;
        if (accept) begin
            state_nxt = WAIT;
        end else if (rsp_fire) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            epoch <= 1'b0;
        end else begin
            state <= state_nxt;
            if (redirectValid) begin
                pc    <= redirectPc;
                epoch <= ~epoch;
            end else if (accept) begin
                pc <= bpHit ? bpTarget : pc + 32'd4;
            end
        end
    end

    // Issue boundary: snapshot of the request now in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend <= '{pc:          pc,
                      pred_taken:  bpHit,
                      pred_target: bpHit ? bpTarget : 32'd0,
                      epoch:       epoch};
        end
    end

    assign push_entry = '{pc:          pend.pc,
                          instr:       imemRspData,
                          pred_taken:  pend.pred_taken,
                          pred_target: pend.pred_target};

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirectValid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (decReady),
        .head       (head),
        .valid      (head_valid),
        .count      (count)
    );

    assign bpPc          = pc;
    assign imemReqAddr   = pc;
    assign imemReqValid  = req_valid;
    assign decValid      = head_valid;
    assign decInstr      = head.instr;
    assign decPc         = head.pc;
    assign decPredTaken  = head_valid && head.pred_taken;
    assign decPredTarget = head.pred_target;

endmodule
